// File: rtl/debounce_switch_bank.sv
// Bank of independent switch debouncers: synchroniser, stable-sample filter,
// press/release pulses, and a per-channel hold/auto-repeat state machine.
module debounce_switch_bank #(
   parameter int NUM_CH          = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int SYNC_STAGES     = 2,
   parameter int HOLD_CYCLES     = 25000000,
   parameter int REPEAT_CYCLES   = 5000000
) (
   input  logic              clk,
   input  logic              i_Reset,
   input  logic [NUM_CH-1:0] i_Switch,
   output logic [NUM_CH-1:0] o_Switch,
   output logic [NUM_CH-1:0] o_Press,
   output logic [NUM_CH-1:0] o_Release,
   output logic [NUM_CH-1:0] o_Hold,
   output logic [NUM_CH-1:0] o_Repeat
);

   localparam int DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W     = $clog2(HOLD_CYCLES + 1);
   localparam int REP_W      = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
   localparam int REP_LAST_I = (REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0;

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_LAST_I);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } state_e;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
      logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
      logic [REP_W-1:0]       rep_cnt_q, rep_cnt_d;
      state_e                 state_q, state_d;
      logic sw_q, sw_d;
      logic press_q, press_d;
      logic release_q, release_d;
      logic hold_q, hold_d;
      logic repeat_q, repeat_d;
      logic sync_s, accept_s, rise_s, fall_s;

      // Synchroniser shift and stable-sample filter
      always_comb begin
         sync_d   = {sync_q[SYNC_STAGES-2:0], i_Switch[g]};
         sync_s   = sync_q[SYNC_STAGES-1];
         accept_s = 1'b0;
         sw_d     = sw_q;
         db_cnt_d = '0;
         if (sync_s != sw_q) begin
            if (db_cnt_q == DB_LAST) begin
               accept_s = 1'b1;
               sw_d     = sync_s;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end else begin
            db_cnt_d = '0;
         end
         rise_s    = accept_s & sync_s;
         fall_s    = accept_s & ~sync_s;
         press_d   = rise_s;
         release_d = fall_s;
      end

      // Hold / repeat next state; a falling edge always wins over a due repeat
      always_comb begin
         state_d    = state_q;
         hold_cnt_d = '0;
         rep_cnt_d  = '0;
         repeat_d   = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (rise_s) begin
                  state_d = ST_PRESSED;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_PRESSED: begin
               if (fall_s) begin
                  state_d = ST_IDLE;
               end else if (hold_cnt_q == HOLD_LAST) begin
                  state_d = ST_HELD;
               end else begin
                  hold_cnt_d = hold_cnt_q + HOLD_W'(1);
               end
            end
            ST_HELD: begin
               if (fall_s) begin
                  state_d = ST_IDLE;
               end else if (REPEAT_CYCLES == 0) begin
                  rep_cnt_d = '0;
               end else if (rep_cnt_q == REP_LAST) begin
                  repeat_d = 1'b1;
               end else begin
                  rep_cnt_d = rep_cnt_q + REP_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
         hold_d = (state_d == ST_HELD);
      end

      // Channel state registers
      always_ff @(posedge clk) begin
         if (i_Reset) begin
            sync_q     <= '0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            state_q    <= ST_IDLE;
            sw_q       <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            hold_q     <= 1'b0;
            repeat_q   <= 1'b0;
         end else begin
            sync_q     <= sync_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            state_q    <= state_d;
            sw_q       <= sw_d;
            press_q    <= press_d;
            release_q  <= release_d;
            hold_q     <= hold_d;
            repeat_q   <= repeat_d;
         end
      end

      assign o_Switch[g]  = sw_q;
      assign o_Press[g]   = press_q;
      assign o_Release[g] = release_q;
      assign o_Hold[g]    = hold_q;
      assign o_Repeat[g]  = repeat_q;
   end

endmodule

// File: tb/tb_debounce_switch_bank.sv
// Directed bench for debounce_switch_bank: a window-based reference model is
// compared on every cycle, plus hand-computed timing checks.
module tb_debounce_switch_bank;
   localparam int NUM_CH = 4;
   localparam int DC     = 4;
   localparam int SS     = 2;
   localparam int HC     = 10;
   localparam int RC     = 3;
   localparam int MAXT   = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              i_Reset  = 1'b1;
   logic [NUM_CH-1:0] i_Switch = '0;
   logic [NUM_CH-1:0] o_Switch, o_Press, o_Release, o_Hold, o_Repeat;

   debounce_switch_bank #(
      .NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS),
      .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC)
   ) dut (
      .clk(clk), .i_Reset(i_Reset), .i_Switch(i_Switch),
      .o_Switch(o_Switch), .o_Press(o_Press), .o_Release(o_Release),
      .o_Hold(o_Hold), .o_Repeat(o_Repeat)
   );

   int total = 0;
   int bad   = 0;
   int t     = 0;
   int last_rst = 0;

   bit smp [NUM_CH][MAXT];
   bit deb [NUM_CH];
   int press_edge [NUM_CH];
   logic [NUM_CH-1:0] e_sw, e_pr, e_rl, e_ho, e_rp;

   int ev_press [NUM_CH];
   int ev_rel   [NUM_CH];
   int ev_hold  [NUM_CH];
   int n_press  [NUM_CH];
   int n_rel    [NUM_CH];
   int rep_off [$];
   logic rep_at_rel = 1'bx;
   int rel_off = -1;
   logic [NUM_CH-1:0] prev_hold = '0;
   int s;

   task automatic check_vec(input string name, input logic [NUM_CH-1:0] act,
                            input logic [NUM_CH-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0d actual=%b required=%b", name, t, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s t=%0d actual=%0d required=%0d", name, t, act, exp);
      end
   endtask

   // Synchronised value the filter sees at edge k: the raw sample SS edges earlier,
   // or 0 if that sample predates the last reset.
   function automatic bit sync_used(input int ch, input int k);
      if (k - SS <= last_rst) return 1'b0;
      return smp[ch][k-SS];
   endfunction

   task automatic model_step();
      bit su, ok, rise, fall, held;
      int since;
      e_sw = '0; e_pr = '0; e_rl = '0; e_ho = '0; e_rp = '0;
      if (i_Reset) begin
         last_rst = t;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            smp[ch][t]     = 1'b0;
            deb[ch]        = 1'b0;
            press_edge[ch] = -1;
         end
      end else begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            smp[ch][t] = i_Switch[ch];
            su   = sync_used(ch, t);
            rise = 1'b0;
            fall = 1'b0;
            // A new level is taken once the last DC filter samples all show it.
            if ((t - last_rst >= DC) && (su != deb[ch])) begin
               ok = 1'b1;
               for (int k = t - DC + 1; k <= t; k++)
                  if (sync_used(ch, k) != su) ok = 1'b0;
               if (ok) begin
                  deb[ch] = su;
                  rise = su;
                  fall = ~su;
               end
            end
            if (rise) press_edge[ch] = t;
            if (fall) press_edge[ch] = -1;
            held  = deb[ch] && (press_edge[ch] >= 0) && (t - press_edge[ch] >= HC);
            since = t - press_edge[ch] - HC;
            e_sw[ch] = deb[ch];
            e_pr[ch] = rise;
            e_rl[ch] = fall;
            e_ho[ch] = held;
            e_rp[ch] = held && (RC > 0) && (since > 0) && ((since % RC) == 0);
         end
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         t++;
         model_step();
         @(negedge clk);
         check_vec("o_Switch",  o_Switch,  e_sw);
         check_vec("o_Press",   o_Press,   e_pr);
         check_vec("o_Release", o_Release, e_rl);
         check_vec("o_Hold",    o_Hold,    e_ho);
         check_vec("o_Repeat",  o_Repeat,  e_rp);
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (o_Press[ch] === 1'b1) begin
               ev_press[ch] = t;
               n_press[ch]++;
            end
            if (o_Release[ch] === 1'b1) begin
               ev_rel[ch] = t;
               n_rel[ch]++;
            end
            if (o_Hold[ch] === 1'b1 && prev_hold[ch] !== 1'b1) ev_hold[ch] = t;
         end
         if (o_Repeat[2] === 1'b1) rep_off.push_back(t - ev_hold[2]);
         if (o_Release[2] === 1'b1) begin
            rep_at_rel = o_Repeat[2];
            rel_off    = t - ev_hold[2];
         end
         prev_hold = o_Hold;
      end
   endtask

   initial begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
         ev_press[ch] = -1; ev_rel[ch] = -1; ev_hold[ch] = -1;
         n_press[ch] = 0;   n_rel[ch] = 0;   press_edge[ch] = -1;
      end

      // Reset, then the first edge after release still shows all-zero outputs
      i_Reset = 1'b1;
      tick(3);
      i_Reset = 1'b0;
      tick(1);
      check_vec("post_reset_all", o_Switch | o_Press | o_Release | o_Hold | o_Repeat, 4'b0000);

      // Clean step on channel 0: press on the 6th edge counting the sampling edge
      i_Switch = 4'b0001;
      s = t + 1;
      tick(8);
      check_int("ch0_press_latency", ev_press[0] - s + 1, 6);
      check_int("ch0_press_count", n_press[0], 1);
      i_Switch = 4'b0000;
      tick(8);
      check_int("ch0_release_count", n_rel[0], 1);

      // Three-sample glitch on channel 1 is rejected, four samples are accepted
      i_Switch = 4'b0010;
      tick(3);
      i_Switch = 4'b0000;
      tick(10);
      check_int("ch1_glitch_press", n_press[1], 0);
      check_int("ch1_glitch_rel", n_rel[1], 0);
      i_Switch = 4'b0010;
      s = t + 1;
      tick(4);
      i_Switch = 4'b0000;
      tick(12);
      check_int("ch1_press4_count", n_press[1], 1);
      check_int("ch1_press4_edge", ev_press[1] - s, 5);
      check_int("ch1_rel4_count", n_rel[1], 1);

      // Channel 2 held for 30 samples: hold and six repeat pulses
      rep_off.delete();
      i_Switch = 4'b0100;
      tick(30);
      i_Switch = 4'b0000;
      tick(10);
      check_int("ch2_hold_delay", ev_hold[2] - ev_press[2], 10);
      check_int("ch2_rep_count", rep_off.size(), 6);
      if (rep_off.size() >= 3) begin
         check_int("ch2_rep1", rep_off[0], 3);
         check_int("ch2_rep2", rep_off[1], 6);
         check_int("ch2_rep3", rep_off[2], 9);
      end
      check_int("ch2_rel_offset", rel_off, 20);

      // Release timed to land on a repeat-due edge: release wins
      rep_off.delete();
      i_Switch = 4'b0100;
      tick(13);
      i_Switch = 4'b0000;
      tick(10);
      check_int("ch2_rel_on_rep_offset", rel_off, 3);
      check_int("ch2_rep_suppressed", int'(rep_at_rel), 0);
      check_int("ch2_no_rep_pulse", rep_off.size(), 0);

      // Reset while channel 3 is held; press returns 6 edges after reset release
      i_Switch = 4'b1000;
      tick(18);
      check_int("ch3_held_before_reset", int'(o_Hold[3]), 1);
      i_Reset = 1'b1;
      tick(1);
      check_vec("reset_clears_all", o_Switch | o_Press | o_Release | o_Hold | o_Repeat, 4'b0000);
      i_Reset = 1'b0;
      s = t + 1;
      tick(8);
      check_int("ch3_press_after_reset", ev_press[3] - s + 1, 6);
      i_Switch = 4'b0000;
      tick(10);

      // All channels pulse together with a four-sample stable pulse
      i_Switch = 4'b1111;
      s = t + 1;
      tick(4);
      i_Switch = 4'b0000;
      tick(12);
      for (int ch = 0; ch < NUM_CH; ch++) begin
         check_int($sformatf("all_press_ch%0d", ch), ev_press[ch] - s, 5);
         check_int($sformatf("all_rel_ch%0d", ch), ev_rel[ch] - s, 9);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
